fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised instruction-fetch stage for the next-generation core. Decouples PC sequencing from decode.
//  Drives a synchronous (1-cycle read latency) instruction ROM and buffers fetched words in a DEPTH-entry prefetch FIFO.
//  Presents instructions, each with its PC, on a valid/ready interface to decode.
//  Accepts branch/jump redirects that flush all buffered and in-flight fetches.
// PARAMETERS
//  SIZE        32   instruction word width
//  ADDR_WIDTH  10   ROM word-address width
//  DEPTH       4    prefetch FIFO entries; power of 2, >=2
//  BYTE_ADDR   0    0: PC is a word address, +1 per fetch; 1: PC is a byte address, +4 per fetch
//  RESET_PC    0    PC value after reset
//  PC_WIDTH (localparam) = ADDR_WIDTH + (BYTE_ADDR ? 2 : 0)
// PORTS
//  CLK          in   1           clock, rising edge
//  RESET        in   1           asynchronous, active-high reset
//  ROM_EN       out  1           ROM read request this cycle
//  ADDR_ROM     out  ADDR_WIDTH  ROM word address = BYTE_ADDR ? fetch_pc[PC_WIDTH-1:2] : fetch_pc
//  Q_ROM        in   SIZE        ROM data, valid the cycle after ROM_EN
//  INSTR        out  SIZE        FIFO head instruction
//  INSTR_PC     out  PC_WIDTH    PC of INSTR
//  INSTR_VALID  out  1           FIFO not empty
//  INSTR_READY  in   1           decode accepts head this cycle
//  REDIRECT     in   1           flush and restart fetch at REDIRECT_PC
//  REDIRECT_PC  in   PC_WIDTH    new fetch PC
//  MISALIGN     out  1           1-cycle pulse: redirect target not word aligned (BYTE_ADDR=1 only)
// BEHAVIOUR
//  Reset values:
//   - fetch_pc=RESET_PC; ROM_EN, INSTR_VALID, MISALIGN = 0; INSTR, INSTR_PC = 0.
//   - FIFO empty; inflight=0; rd/wr pointers=0.
//  Issue:
//   - ROM_EN=1 iff !REDIRECT && (count+inflight) < DEPTH.
//   - On issue: fetch_pc += (BYTE_ADDR?4:1) mod 2^PC_WIDTH; inflight<=1, req_pc<=fetch_pc.
//   - No issue: inflight<=0.
//  Response:
//   - When inflight=1 and no REDIRECT, {Q_ROM, req_pc} is written to FIFO tail at the clock edge.
//   - The credit check above guarantees the FIFO never overflows.
//  Output:
//   - Show-ahead FIFO. Pop occurs on INSTR_VALID && INSTR_READY.
//   - INSTR/INSTR_PC stay stable while VALID && !READY.
//   - Push and pop in the same cycle leave count unchanged.
//  Latency: first ROM_EN in the first cycle after RESET falls; INSTR_VALID two cycles after that issue.
//  Throughput: sustained 1 instr/cycle while READY is held high.
//  Full: count==DEPTH -> ROM_EN=0, fetch_pc holds.
//  Empty: INSTR_VALID=0; INSTR holds last value (don't-care).
//  REDIRECT (highest priority, single cycle):
//   - FIFO cleared (count=0, pointers reset); the in-flight response is discarded; no issue this cycle.
//   - fetch_pc <= REDIRECT_PC, with [1:0] forced to 0 if BYTE_ADDR=1.
//   - A handshake in the redirect cycle counts as accepted by decode but has no further effect.
//   - Next cycle: issue from the new PC.
//  MISALIGN: registered; 1 for the cycle after REDIRECT when BYTE_ADDR=1 && REDIRECT_PC[1:0]!=0; else 0.
//  Wrap: fetch_pc wraps from max to 0 silently.
//  Reset mid-operation: every register returns to its reset value asynchronously; in-flight data is lost.
// TESTING
//  1. Reset, BYTE_ADDR=0, READY=1, ROM[i]=i+100 -> ADDR_ROM 0,1,2..; INSTR 100,101.. with PC 0,1..; VALID from 3rd cycle, then every cycle.
//  2. READY=0 for 10 cycles -> exactly DEPTH=4 issues, then ROM_EN=0; VALID=1 with head PC 0 stable.
//     Then READY=1 -> PCs 0..5 in order, no gaps or duplicates.
//  3. Steady stream, REDIRECT=1 with REDIRECT_PC=0x40 -> VALID=0 for two cycles; next INSTR_PC=0x40, 0x41; stale and in-flight words never appear.
//  4. BYTE_ADDR=1, REDIRECT_PC=0x106 -> MISALIGN pulses once; ADDR_ROM=0x41; INSTR_PC=0x104, 0x108.
//  5. RESET_PC=2^PC_WIDTH-2 -> PCs wrap ...FE, FF, 0, 1 (ADDR_WIDTH=8).
//  6. RESET asserted mid-stream with FIFO half full -> all outputs are 0 immediately; restart from RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequences the PC into a 1-cycle-latency ROM and buffers
// returned words with their PCs in a show-ahead prefetch FIFO for decode.
module fetch_unit #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 4,
  parameter int BYTE_ADDR  = 0,
  parameter int RESET_PC   = 0,
  localparam int PC_WIDTH  = ADDR_WIDTH + ((BYTE_ADDR != 0) ? 2 : 0)
) (
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  ROM_EN,
  output logic [ADDR_WIDTH-1:0] ADDR_ROM,
  input  logic [SIZE-1:0]       Q_ROM,
  output logic [SIZE-1:0]       INSTR,
  output logic [PC_WIDTH-1:0]   INSTR_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  input  logic                  REDIRECT,
  input  logic [PC_WIDTH-1:0]   REDIRECT_PC,
  output logic                  MISALIGN
);

  // Decode handshake: INSTR/INSTR_PC are meaningful while INSTR_VALID is high and
  // are held stable until the cycle INSTR_READY is also high, when the head is
  // consumed at the clock edge. A handshake in a REDIRECT cycle is dropped.

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]      DEPTH_W    = (CNT_W + 1)'(DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'((BYTE_ADDR != 0) ? 4 : 1);
  localparam logic [PC_WIDTH-1:0] PC_RESET   = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = (BYTE_ADDR != 0) ? ~PC_WIDTH'(3) : '1;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] req_pc;
  logic                inflight;
  logic                misalign_q;

  logic [SIZE-1:0]     mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;

  logic [CNT_W:0]      occupancy;
  logic                issue;
  logic                push;
  logic                pop;

  // Credit check counts the in-flight read, so the FIFO can never overflow.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (!RESET && !REDIRECT) begin
      issue = (occupancy < DEPTH_W);
      push  = inflight;
      pop   = (count != '0) && INSTR_READY;
    end
  end

  if (BYTE_ADDR != 0) begin : g_byte_addr
    assign ADDR_ROM = fetch_pc[PC_WIDTH-1:2];
  end else begin : g_word_addr
    assign ADDR_ROM = fetch_pc;
  end

  assign ROM_EN      = issue;
  assign INSTR       = mem_instr[rd_ptr];
  assign INSTR_PC    = mem_pc[rd_ptr];
  assign INSTR_VALID = (count != '0);
  assign MISALIGN    = misalign_q;

  // PC sequencing and the single outstanding ROM request.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_pc   <= PC_RESET;
      req_pc     <= '0;
      inflight   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (REDIRECT) begin
        fetch_pc   <= REDIRECT_PC & ALIGN_MASK;
        inflight   <= 1'b0;
        misalign_q <= (BYTE_ADDR != 0) && (REDIRECT_PC[1:0] != 2'b00);
      end else if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
        req_pc   <= fetch_pc;
        inflight <= 1'b1;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // Prefetch FIFO storage; entries are cleared on reset so INSTR/INSTR_PC start at 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= '0;
        mem_pc[i]    <= '0;
      end
    end else if (push) begin
      mem_instr[wr_ptr] <= Q_ROM;
      mem_pc[wr_ptr]    <= req_pc;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (REDIRECT) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: three configurations (word PC, byte PC, wrapping 8-bit PC)
// share stimulus and are checked every cycle against a queue-based fetch model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic redirect = 1'b0;
  logic ready = 1'b0;
  int   rpc_v [3];

  int total = 0;
  int bad = 0;

  // configuration per instance: a = word/10b, b = byte/12b, c = word/8b from 254
  int pcw [3]    = '{10, 12, 8};
  bit byte_m [3] = '{1'b0, 1'b1, 1'b0};
  int rst_pc [3] = '{0, 0, 254};

  logic        en_a, en_b, en_c;
  logic [9:0]  addr_a, addr_b;
  logic [7:0]  addr_c;
  logic [31:0] q_a, q_b, q_c;
  logic [31:0] instr_a, instr_b, instr_c;
  logic [9:0]  pc_a;
  logic [11:0] pc_b;
  logic [7:0]  pc_c;
  logic        valid_a, valid_b, valid_c;
  logic        mis_a, mis_b, mis_c;
  logic [9:0]  rpc_a;
  logic [11:0] rpc_b;
  logic [7:0]  rpc_c;

  assign rpc_a = 10'(rpc_v[0]);
  assign rpc_b = 12'(rpc_v[1]);
  assign rpc_c = 8'(rpc_v[2]);

  always #5 clk = ~clk;

  fetch_unit #(.SIZE(32), .ADDR_WIDTH(10), .DEPTH(4), .BYTE_ADDR(0), .RESET_PC(0)) u_a (
    .CLK(clk), .RESET(rst), .ROM_EN(en_a), .ADDR_ROM(addr_a), .Q_ROM(q_a),
    .INSTR(instr_a), .INSTR_PC(pc_a), .INSTR_VALID(valid_a), .INSTR_READY(ready),
    .REDIRECT(redirect), .REDIRECT_PC(rpc_a), .MISALIGN(mis_a));

  fetch_unit #(.SIZE(32), .ADDR_WIDTH(10), .DEPTH(4), .BYTE_ADDR(1), .RESET_PC(0)) u_b (
    .CLK(clk), .RESET(rst), .ROM_EN(en_b), .ADDR_ROM(addr_b), .Q_ROM(q_b),
    .INSTR(instr_b), .INSTR_PC(pc_b), .INSTR_VALID(valid_b), .INSTR_READY(ready),
    .REDIRECT(redirect), .REDIRECT_PC(rpc_b), .MISALIGN(mis_b));

  fetch_unit #(.SIZE(32), .ADDR_WIDTH(8), .DEPTH(4), .BYTE_ADDR(0), .RESET_PC(254)) u_c (
    .CLK(clk), .RESET(rst), .ROM_EN(en_c), .ADDR_ROM(addr_c), .Q_ROM(q_c),
    .INSTR(instr_c), .INSTR_PC(pc_c), .INSTR_VALID(valid_c), .INSTR_READY(ready),
    .REDIRECT(redirect), .REDIRECT_PC(rpc_c), .MISALIGN(mis_c));

  function automatic logic [31:0] rom_word(input int a);
    return 32'((a << 20) + a + 100);
  endfunction

  // synchronous ROMs, one-cycle read latency
  always @(posedge clk) begin
    if (en_a) q_a <= rom_word(int'(addr_a));
    if (en_b) q_b <= rom_word(int'(addr_b));
    if (en_c) q_c <= rom_word(int'(addr_c));
  end

  logic [31:0] o_en [3], o_addr [3], o_valid [3], o_instr [3], o_pc [3], o_mis [3];
  assign o_en[0] = 32'(en_a);       assign o_en[1] = 32'(en_b);       assign o_en[2] = 32'(en_c);
  assign o_addr[0] = 32'(addr_a);   assign o_addr[1] = 32'(addr_b);  assign o_addr[2] = 32'(addr_c);
  assign o_valid[0] = 32'(valid_a); assign o_valid[1] = 32'(valid_b); assign o_valid[2] = 32'(valid_c);
  assign o_instr[0] = instr_a;      assign o_instr[1] = instr_b;      assign o_instr[2] = instr_c;
  assign o_pc[0] = 32'(pc_a);       assign o_pc[1] = 32'(pc_b);       assign o_pc[2] = 32'(pc_c);
  assign o_mis[0] = 32'(mis_a);     assign o_mis[1] = 32'(mis_b);     assign o_mis[2] = 32'(mis_c);

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] t=%0t got=%0h want=%0h", name, k, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each instance: next PC to fetch, the PC of the word the ROM is returning,
  // and a queue of PCs fetched but not yet taken by decode.
  int m_pc [3];
  int m_req [3];
  bit m_infl [3];
  bit m_mis [3];
  int mq0 [$];
  int mq1 [$];
  int mq2 [$];

  function automatic int qsize(input int k);
    if (k == 0) return mq0.size();
    if (k == 1) return mq1.size();
    return mq2.size();
  endfunction

  function automatic int qhead(input int k);
    if (k == 0) return mq0[0];
    if (k == 1) return mq1[0];
    return mq2[0];
  endfunction

  task automatic qpush(input int k, input int v);
    if (k == 0) mq0.push_back(v);
    else if (k == 1) mq1.push_back(v);
    else mq2.push_back(v);
  endtask

  task automatic qpop(input int k);
    if (k == 0) void'(mq0.pop_front());
    else if (k == 1) void'(mq1.pop_front());
    else void'(mq2.pop_front());
  endtask

  task automatic qclear(input int k);
    if (k == 0) mq0.delete();
    else if (k == 1) mq1.delete();
    else mq2.delete();
  endtask

  function automatic int pmask(input int k);
    return (1 << pcw[k]) - 1;
  endfunction

  function automatic int word_of(input int k, input int pc);
    return byte_m[k] ? (pc >> 2) : pc;
  endfunction

  function automatic bit exp_en(input int k);
    return !rst && !redirect && ((qsize(k) + int'(m_infl[k])) < 4);
  endfunction

  task automatic model_step(input int k);
    bit can_issue;
    can_issue = (qsize(k) + int'(m_infl[k])) < 4;
    if (redirect) begin
      qclear(k);
      m_infl[k] = 1'b0;
      m_pc[k]   = (rpc_v[k] & pmask(k)) & (byte_m[k] ? ~3 : ~0);
      m_mis[k]  = byte_m[k] && ((rpc_v[k] & 3) != 0);
    end else begin
      m_mis[k] = 1'b0;
      if (qsize(k) > 0 && ready) qpop(k);
      if (m_infl[k]) qpush(k, m_req[k]);
      if (can_issue) begin
        m_req[k]  = m_pc[k];
        m_pc[k]   = (m_pc[k] + (byte_m[k] ? 4 : 1)) & pmask(k);
        m_infl[k] = 1'b1;
      end else begin
        m_infl[k] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_pc[k] = rst_pc[k];
        m_req[k] = 0;
        m_infl[k] = 1'b0;
        m_mis[k] = 1'b0;
        qclear(k);
      end else begin
        model_step(k);
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("rom_en", k, o_en[k], 32'(exp_en(k)));
      chk("addr_rom", k, o_addr[k], 32'(word_of(k, m_pc[k])));
      chk("valid", k, o_valid[k], 32'(qsize(k) > 0));
      chk("misalign", k, o_mis[k], 32'(m_mis[k]));
      if (qsize(k) > 0) begin
        chk("instr_pc", k, o_pc[k], 32'(qhead(k)));
        chk("instr", k, o_instr[k], rom_word(word_of(k, qhead(k))));
      end
    end
  end

  // ---------------- stimulus with literal expectations ----------------
  initial begin
    int issues;
    int seen;
    for (int k = 0; k < 3; k++) rpc_v[k] = 0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // startup stream: first issue at once, first instruction two cycles later
    #1; chk("t1_en", 0, o_en[0], 32'd1); chk("t1_addr", 0, o_addr[0], 32'd0);
    chk("t1_valid0", 0, o_valid[0], 32'd0); chk("t1_addr_c", 2, o_addr[2], 32'd254);
    @(negedge clk); #1;
    chk("t1_addr1", 0, o_addr[0], 32'd1); chk("t1_valid1", 0, o_valid[0], 32'd0);
    @(negedge clk); #1;
    chk("t1_valid2", 0, o_valid[0], 32'd1); chk("t1_pc0", 0, o_pc[0], 32'd0);
    chk("t1_instr0", 0, o_instr[0], 32'd100); chk("t5_pc_fe", 2, o_pc[2], 32'd254);
    @(negedge clk); #1;
    chk("t1_pc1", 0, o_pc[0], 32'd1); chk("t1_instr1", 0, o_instr[0], 32'h0010_0065);
    chk("t5_pc_ff", 2, o_pc[2], 32'd255);
    @(negedge clk); #1;
    chk("t5_pc_wrap", 2, o_pc[2], 32'd0);
    repeat (4) @(negedge clk);

    // redirect: a to 0x40, b to misaligned 0x106
    redirect = 1'b1;
    rpc_v[0] = 32'h40; rpc_v[1] = 32'h106; rpc_v[2] = 32'h33;
    #1; chk("t3_en_redir", 0, o_en[0], 32'd0);
    @(negedge clk); redirect = 1'b0; #1;
    chk("t4_mis", 1, o_mis[1], 32'd1); chk("t4_addr", 1, o_addr[1], 32'h41);
    chk("t3_addr", 0, o_addr[0], 32'h40); chk("t3_valid_a", 0, o_valid[0], 32'd0);
    @(negedge clk); #1;
    chk("t3_valid_b", 0, o_valid[0], 32'd0); chk("t4_mis_end", 1, o_mis[1], 32'd0);
    @(negedge clk); #1;
    chk("t3_valid_c", 0, o_valid[0], 32'd1); chk("t3_pc40", 0, o_pc[0], 32'h40);
    chk("t4_pc104", 1, o_pc[1], 32'h104);
    @(negedge clk); #1;
    chk("t3_pc41", 0, o_pc[0], 32'h41); chk("t4_pc108", 1, o_pc[1], 32'h108);

    // reset mid-stream with the FIFO partly filled
    @(negedge clk); ready = 1'b0;
    repeat (2) @(negedge clk);
    #1; rst = 1'b1; #1;
    chk("t6_en", 0, o_en[0], 32'd0); chk("t6_addr", 0, o_addr[0], 32'd0);
    chk("t6_instr", 0, o_instr[0], 32'd0); chk("t6_pc", 0, o_pc[0], 32'd0);
    chk("t6_valid", 0, o_valid[0], 32'd0); chk("t6_instr_b", 1, o_instr[1], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // stalled decode: exactly four issues, head held at PC 0
    issues = 0;
    for (int i = 0; i < 10; i++) begin
      #1; if (en_a) issues++;
      @(negedge clk);
    end
    #1;
    chk("t2_issues", 0, 32'(issues), 32'd4); chk("t2_en_full", 0, o_en[0], 32'd0);
    chk("t2_valid", 0, o_valid[0], 32'd1); chk("t2_head", 0, o_pc[0], 32'd0);
    @(negedge clk); ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen < 6; i++) begin
      #1;
      if (valid_a) begin
        chk("t2_order", 0, o_pc[0], 32'(seen));
        seen++;
      end
      @(negedge clk);
    end
    chk("t2_drain_count", 0, 32'(seen), 32'd6);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ready    = ($urandom_range(0, 3) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < 3; k++) rpc_v[k] = int'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; redirect = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
